// File: rtl/alarm_time_ctrl.sv
// Alarm clock core: time of day, alarm setting, mode FSM and alarm ring/snooze FSM.
// All state updates on clk. disp_* is a mode-selected mux of the registered fields.
module alarm_time_ctrl #(
  parameter int SEC_PER_MIN      = 60,
  parameter int SNOOZE_MIN       = 9,
  parameter int RING_TIMEOUT_MIN = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic       mode_pb,
  input  logic       hr_pb,
  input  logic       min_pb,
  input  logic       arm_pb,
  input  logic       snooze_pb,
  output logic [1:0] mode,
  output logic [4:0] disp_hours,
  output logic [5:0] disp_minutes,
  output logic [5:0] seconds,
  output logic       alarm_armed,
  output logic       ringing
);

  localparam int SW = $clog2(SNOOZE_MIN + 1);
  localparam int RW = $clog2(RING_TIMEOUT_MIN + 1);
  localparam logic [5:0]    SEC_LAST  = 6'(SEC_PER_MIN - 1);
  localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNOOZE_MIN);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_TIMEOUT_MIN - 1);

  typedef enum logic [1:0] {
    M_RUN       = 2'd0,
    M_SET_TIME  = 2'd1,
    M_SET_ALARM = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    A_IDLE    = 2'd0,
    A_RINGING = 2'd1,
    A_SNOOZED = 2'd2
  } alarm_t;

  mode_t         mode_q, mode_d;
  alarm_t        al_state, al_next;
  logic [4:0]    tm_hr_q, tm_hr_d, al_hr_q, al_hr_d;
  logic [5:0]    tm_min_q, tm_min_d, al_min_q, al_min_d;
  logic [5:0]    tm_sec_q, tm_sec_d;
  logic          armed_q, armed_d;
  logic [RW-1:0] ring_cnt, ring_d;
  logic [SW-1:0] snz_cnt, snz_d;
  logic          minute_strobe;
  logic          alarm_hit;

  function automatic logic [4:0] inc_hr(input logic [4:0] h);
    return (h == 5'd23) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [5:0] inc_min(input logic [5:0] m);
    return (m == 6'd59) ? 6'd0 : m + 6'd1;
  endfunction

  always_comb begin
    mode_d = mode_q;
    if (mode_pb) begin
      case (mode_q)
        M_RUN:      mode_d = M_SET_TIME;
        M_SET_TIME: mode_d = M_SET_ALARM;
        default:    mode_d = M_RUN;
      endcase
    end
  end

  // Edits act on the mode held before any coincident mode_pb transition.
  always_comb begin
    tm_hr_d       = tm_hr_q;
    tm_min_d      = tm_min_q;
    tm_sec_d      = tm_sec_q;
    minute_strobe = 1'b0;
    if (mode_q == M_SET_TIME) begin
      if (hr_pb) tm_hr_d = inc_hr(tm_hr_q);
      if (min_pb) begin
        tm_min_d = inc_min(tm_min_q);
        tm_sec_d = 6'd0;
      end
    end else if (sec_tick) begin
      if (tm_sec_q == SEC_LAST) begin
        minute_strobe = 1'b1;
        tm_sec_d      = 6'd0;
        tm_min_d      = inc_min(tm_min_q);
        if (tm_min_q == 6'd59) tm_hr_d = inc_hr(tm_hr_q);
      end else begin
        tm_sec_d = tm_sec_q + 6'd1;
      end
    end
  end

  always_comb begin
    al_hr_d  = al_hr_q;
    al_min_d = al_min_q;
    if (mode_q == M_SET_ALARM) begin
      if (hr_pb)  al_hr_d  = inc_hr(al_hr_q);
      if (min_pb) al_min_d = inc_min(al_min_q);
    end
  end

  // Match is taken against the post-increment time so ringing rises with the minute.
  assign alarm_hit = minute_strobe && (tm_hr_d == al_hr_q) && (tm_min_d == al_min_q);

  always_comb begin
    al_next = al_state;
    armed_d = armed_q;
    ring_d  = ring_cnt;
    snz_d   = snz_cnt;
    case (al_state)
      A_IDLE: begin
        if (arm_pb) begin
          armed_d = ~armed_q;
        end else if (armed_q && alarm_hit) begin
          al_next = A_RINGING;
          ring_d  = '0;
        end
      end
      A_RINGING: begin
        if (arm_pb) begin
          al_next = A_IDLE;
          armed_d = 1'b0;
        end else if (snooze_pb) begin
          al_next = A_SNOOZED;
          snz_d   = SNZ_LOAD;
        end else if (minute_strobe) begin
          ring_d = ring_cnt + RW'(1);
          if (ring_cnt == RING_LAST) al_next = A_IDLE;
        end
      end
      A_SNOOZED: begin
        if (arm_pb) begin
          al_next = A_IDLE;
          armed_d = 1'b0;
        end else if (minute_strobe) begin
          snz_d = snz_cnt - SW'(1);
          if (snz_cnt == SW'(1)) begin
            al_next = A_RINGING;
            ring_d  = '0;
          end
        end
      end
      default: al_next = A_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= M_RUN;
      al_state <= A_IDLE;
      tm_hr_q  <= 5'd0;
      tm_min_q <= 6'd0;
      tm_sec_q <= 6'd0;
      al_hr_q  <= 5'd7;
      al_min_q <= 6'd0;
      armed_q  <= 1'b0;
      ring_cnt <= '0;
      snz_cnt  <= '0;
    end else begin
      mode_q   <= mode_d;
      al_state <= al_next;
      tm_hr_q  <= tm_hr_d;
      tm_min_q <= tm_min_d;
      tm_sec_q <= tm_sec_d;
      al_hr_q  <= al_hr_d;
      al_min_q <= al_min_d;
      armed_q  <= armed_d;
      ring_cnt <= ring_d;
      snz_cnt  <= snz_d;
    end
  end

  assign mode         = mode_q;
  assign disp_hours   = (mode_q == M_SET_ALARM) ? al_hr_q  : tm_hr_q;
  assign disp_minutes = (mode_q == M_SET_ALARM) ? al_min_q : tm_min_q;
  assign seconds      = tm_sec_q;
  assign alarm_armed  = armed_q;
  assign ringing      = (al_state == A_RINGING);

endmodule

// File: doc/alarm_time_ctrl.md
Name: alarm_time_ctrl

Overview:
- Consumes single-cycle debounced button pulses (one per press, registered, synchronous to clk) and owns the alarm clock's state.
- Keeps time of day (HH:MM:SS, 24 h) advanced by a once-per-second enable, holds the alarm setting, and runs a mode FSM for setting time and alarm.
- Runs an alarm FSM with ring timeout and snooze.
- Sits directly downstream of the per-button debouncers; its outputs feed the display driver and buzzer.

Parameters:
- SEC_PER_MIN, 60, seconds per minute; lowered in simulation only; legal range 2..64.
- SNOOZE_MIN, 9, minutes from snooze until re-ring; must be ≥1.
- RING_TIMEOUT_MIN, 5, minutes of unattended ringing before auto-stop; must be ≥1.

Ports:
- clk  in  1  system clock; the block's only clock.
- rst  in  1  synchronous, active-high reset.
- sec_tick  in  1  one-cycle enable, once per second.
- mode_pb  in  1  debounced pulse; cycles mode.
- hr_pb  in  1  debounced pulse; increments hours of the item being set.
- min_pb  in  1  debounced pulse; increments minutes of the item being set.
- arm_pb  in  1  debounced pulse; toggles alarm armed, and stops a ring.
- snooze_pb  in  1  debounced pulse; snoozes a ring.
- mode  out  2  0=RUN, 1=SET_TIME, 2=SET_ALARM.
- disp_hours  out  5  alarm hours in SET_ALARM, otherwise time hours.
- disp_minutes  out  6  alarm minutes in SET_ALARM, otherwise time minutes.
- seconds  out  6  time seconds.
- alarm_armed  out  1  alarm enabled.
- ringing  out  1  buzzer drive.

Behaviour:
- **Clock and reset.** One clock, clk. Reset is synchronous and active-high on rst. On the first edge with rst=1, all of the following load and take precedence over every input:
  - time = 00:00:00
  - alarm = 07:00
  - mode = RUN, alarm_armed = 0, ringing = 0
  - alarm FSM = IDLE, all internal counters = 0
- **Registers and outputs.** All state is registered. disp_* are combinational muxes of registers selected by mode.
- **Mode FSM.**
  - mode_pb moves RUN→SET_TIME→SET_ALARM→RUN.
  - If mode_pb coincides with hr_pb or min_pb, the increment applies to the pre-transition mode.
  - The encoding value 3 is never reached.
- **Time counting.**
  - In RUN and SET_ALARM, sec_tick increments seconds.
  - When seconds==SEC_PER_MIN-1, seconds wraps to 0 and minutes increments. This cycle is the minute_strobe.
  - Minutes 59→0 carries into hours; hours 23→0.
  - In SET_TIME, sec_tick is ignored and no minute_strobe occurs.
- **SET_TIME edits.**
  - hr_pb: hours = (hours+1) mod 24.
  - min_pb: minutes = (minutes+1) mod 60 and seconds cleared to 0. There is no carry into hours.
- **SET_ALARM edits.**
  - hr_pb and min_pb edit alarm hours/minutes with the same mod rules.
  - Time keeps running independently; sec_tick in the same cycle applies to time.
- **RUN.** hr_pb and min_pb are ignored.
- **arm_pb in IDLE.** Toggles alarm_armed, in any mode.
- **Alarm FSM.** States IDLE, RINGING, SNOOZED; ringing=1 only in RINGING.
  - IDLE→RINGING when all of the following hold, and the transition happens on that same edge (ringing rises with the minute update):
    - minute_strobe;
    - alarm_armed=1;
    - the post-increment hours:minutes equals alarm hours:minutes.
  - Edits in SET_TIME/SET_ALARM never trigger.
  - RINGING: ring_cnt is cleared on entry and increments on each minute_strobe. When ring_cnt reaches RING_TIMEOUT_MIN, go to IDLE; alarm_armed stays 1.
  - RINGING + snooze_pb → SNOOZED, with snz_cnt loaded with SNOOZE_MIN.
  - SNOOZED: each minute_strobe decrements snz_cnt. On the strobe that takes it to 0, go to RINGING and clear ring_cnt.
  - RINGING or SNOOZED + arm_pb → IDLE with alarm_armed cleared. arm_pb wins over a coincident snooze_pb or minute_strobe.
  - snooze_pb in IDLE or SNOOZED is ignored.
  - While in SET_TIME, minute_strobe is absent, so the ring and snooze counters freeze.
- **Widths.**
  - snz_cnt is $clog2(SNOOZE_MIN+1) bits.
  - ring_cnt is $clog2(RING_TIMEOUT_MIN+1) bits.
  - No arithmetic may overflow its field.
- **Mid-operation reset.** rst asserted mid-ring or mid-edit returns everything to the reset values on that edge.

Test Plan:
- Reset, then 3 mode_pb pulses → mode goes 1, 2, 0; all pulses with rst=1 held → outputs stay at reset values (07:00 alarm, 00:00:00 time).
- SET_TIME, with 23 hr_pb and 59 min_pb, back to RUN, then SEC_PER_MIN(=4) sec_ticks → display 00:00, seconds 0, hours wrapped 23→0; sec_ticks during SET_TIME → seconds unchanged.
- Alarm 00:01 armed, time 00:00:03 (SEC_PER_MIN=4), one sec_tick → ringing=1 on the same edge minutes become 1; then RING_TIMEOUT_MIN(=2) minute_strobes → ringing=0, alarm_armed=1.
- While ringing, snooze_pb → ringing=0 next cycle; SNOOZE_MIN(=2) minute_strobes later → ringing=1 again; then arm_pb together with snooze_pb → IDLE, alarm_armed=0.
- SET_ALARM with hr_pb and sec_tick in the same cycle → alarm hours+1 and time seconds+1 both apply; SET_TIME edit making time equal alarm → no ring.
- rst pulsed while in SNOOZED at 05:30 → next cycle ringing=0, alarm_armed=0, time 00:00:00, mode RUN.
